// File: rtl/grf_hazard_scoreboard.sv
// Hazard scoreboard for the 5-stage pipeline: tracks GRF writers in E/M/W,
// produces the D-stage stall and forward selects, and drives the GRF write port.
module grf_hazard_scoreboard #(
  parameter int TNEW_W = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_wen,
  input  logic [4:0]        issue_wreg,
  input  logic [TNEW_W-1:0] issue_tnew,
  input  logic              rs_used,
  input  logic [4:0]        rs,
  input  logic [TNEW_W-1:0] rs_tuse,
  input  logic              rt_used,
  input  logic [4:0]        rt,
  input  logic [TNEW_W-1:0] rt_tuse,
  output logic              stall,
  output logic [1:0]        fwd_rs,
  output logic [1:0]        fwd_rt,
  output logic              grf_wen,
  output logic [4:0]        grf_wreg,
  output logic [4:0]        e_wreg,
  output logic [4:0]        m_wreg,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              e_valid_q, e_valid_d, m_valid_q, m_valid_d, w_valid_q, w_valid_d;
  logic [4:0]        e_wreg_q, e_wreg_d, m_wreg_q, m_wreg_d, w_wreg_q, w_wreg_d;
  logic [TNEW_W-1:0] e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d, w_tnew_q, w_tnew_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [2:0]        rs_eval, rt_eval;
  logic              issue_track;

  // Only the youngest matching stage decides; returns {stall, fwd_sel}.
  function automatic logic [2:0] eval_src(input logic used, input logic [4:0] r,
                                          input logic [TNEW_W-1:0] tuse);
    logic hit_e, hit_m, hit_w, stl;
    logic [1:0] sel;
    hit_e = used && (r != 5'd0) && e_valid_q && (e_wreg_q == r);
    hit_m = used && (r != 5'd0) && m_valid_q && (m_wreg_q == r);
    hit_w = used && (r != 5'd0) && w_valid_q && (w_wreg_q == r);
    stl = 1'b0;
    sel = 2'd0;
    if (hit_e) begin
      stl = e_tnew_q > tuse;
      sel = (e_tnew_q == '0) ? 2'd2 : 2'd0;
    end else if (hit_m) begin
      stl = m_tnew_q > tuse;
      sel = (m_tnew_q == '0) ? 2'd1 : 2'd0;
    end else if (hit_w) begin
      stl = w_tnew_q > tuse;
    end
    return {stl, sel};
  endfunction

  function automatic logic [TNEW_W-1:0] dec_sat(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  always_comb begin
    rs_eval = eval_src(rs_used, rs, rs_tuse);
    rt_eval = eval_src(rt_used, rt, rt_tuse);
    stall   = issue_valid && (rs_eval[2] || rt_eval[2]);
    fwd_rs  = rs_eval[1:0];
    fwd_rt  = rt_eval[1:0];
  end

  // Writers to $0 or non-writers enter E as bubbles so they can never match.
  always_comb begin
    issue_track = issue_valid && !stall && issue_wen && (issue_wreg != 5'd0);
    e_valid_d   = issue_track;
    e_wreg_d    = issue_track ? issue_wreg : 5'd0;
    e_tnew_d    = issue_track ? issue_tnew : '0;
    m_valid_d   = e_valid_q;
    m_wreg_d    = e_wreg_q;
    m_tnew_d    = dec_sat(e_tnew_q);
    w_valid_d   = m_valid_q;
    w_wreg_d    = m_wreg_q;
    w_tnew_d    = dec_sat(m_tnew_q);
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid_q   <= 1'b0;
      e_wreg_q    <= 5'd0;
      e_tnew_q    <= '0;
      m_valid_q   <= 1'b0;
      m_wreg_q    <= 5'd0;
      m_tnew_q    <= '0;
      w_valid_q   <= 1'b0;
      w_wreg_q    <= 5'd0;
      w_tnew_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      e_valid_q   <= e_valid_d;
      e_wreg_q    <= e_wreg_d;
      e_tnew_q    <= e_tnew_d;
      m_valid_q   <= m_valid_d;
      m_wreg_q    <= m_wreg_d;
      m_tnew_q    <= m_tnew_d;
      w_valid_q   <= w_valid_d;
      w_wreg_q    <= w_wreg_d;
      w_tnew_q    <= w_tnew_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grf_wen   = w_valid_q;
  assign grf_wreg  = w_wreg_q;
  assign e_wreg    = e_wreg_q;
  assign m_wreg    = m_wreg_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_grf_hazard_scoreboard.sv
// Directed scenarios plus random traffic for grf_hazard_scoreboard, checked
// against a model that keeps the last three issued instructions and their age.
module tb_grf_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_wen, rs_used, rt_used;
  logic [4:0]  issue_wreg, rs, rt;
  logic [1:0]  issue_tnew, rs_tuse, rt_tuse;
  logic        stall, grf_wen;
  logic [1:0]  fwd_rs, fwd_rt;
  logic [4:0]  grf_wreg, e_wreg, m_wreg;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  // Model: slot i holds the instruction issued i+1 cycles ago (0=E,1=M,2=W).
  bit          h_valid [3];
  logic [4:0]  h_wreg  [3];
  int          h_tnew  [3];
  logic [31:0] exp_cnt;
  logic        exp_stall;
  logic        last_stall;
  logic [1:0]  last_fwd_rs, last_fwd_rt;

  grf_hazard_scoreboard #(.TNEW_W(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_wreg(issue_wreg),
    .issue_tnew(issue_tnew),
    .rs_used(rs_used), .rs(rs), .rs_tuse(rs_tuse),
    .rt_used(rt_used), .rt(rt), .rt_tuse(rt_tuse),
    .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .grf_wen(grf_wen), .grf_wreg(grf_wreg),
    .e_wreg(e_wreg), .m_wreg(m_wreg), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Remaining cycles until forwardable: issue tnew minus cycles spent since E.
  function automatic int remaining(input int i);
    return (h_tnew[i] > i) ? h_tnew[i] - i : 0;
  endfunction

  task automatic model_src(input logic used, input logic [4:0] r, input int tuse,
                           output logic st, output logic [1:0] fw);
    bit found = 0;
    st = 1'b0;
    fw = 2'd0;
    if (used && r != 5'd0) begin
      for (int i = 0; i < 3; i++) begin
        if (!found && h_valid[i] && h_wreg[i] == r) begin
          found = 1;
          st = remaining(i) > tuse;
          fw = (remaining(i) == 0 && i < 2) ? 2'(2 - i) : 2'd0;
        end
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      h_valid[i] = 0;
      h_wreg[i]  = 5'd0;
      h_tnew[i]  = 0;
    end
    exp_cnt = 32'd0;
  endtask

  task automatic set_d(input logic iv, input logic wen, input logic [4:0] wr, input logic [1:0] tn,
                       input logic su, input logic [4:0] s, input logic [1:0] stu,
                       input logic tu, input logic [4:0] t, input logic [1:0] ttu);
    issue_valid = iv; issue_wen = wen; issue_wreg = wr; issue_tnew = tn;
    rs_used = su; rs = s; rs_tuse = stu;
    rt_used = tu; rt = t; rt_tuse = ttu;
  endtask

  // One clock: compare all outputs with the model, then clock and advance the model.
  task automatic cyc();
    logic st_s, st_t;
    logic [1:0] fw_s, fw_t;
    #1;
    model_src(rs_used, rs, int'(rs_tuse), st_s, fw_s);
    model_src(rt_used, rt, int'(rt_tuse), st_t, fw_t);
    exp_stall = issue_valid && (st_s || st_t);
    check("stall", 32'(stall), 32'(exp_stall));
    check("fwd_rs", 32'(fwd_rs), 32'(fw_s));
    check("fwd_rt", 32'(fwd_rt), 32'(fw_t));
    check("grf_wen", 32'(grf_wen), 32'(h_valid[2]));
    check("grf_wreg", 32'(grf_wreg), 32'(h_valid[2] ? h_wreg[2] : 5'd0));
    check("e_wreg", 32'(e_wreg), 32'(h_valid[0] ? h_wreg[0] : 5'd0));
    check("m_wreg", 32'(m_wreg), 32'(h_valid[1] ? h_wreg[1] : 5'd0));
    check("stall_cnt", stall_cnt, exp_cnt);
    last_stall  = stall;
    last_fwd_rs = fwd_rs;
    last_fwd_rt = fwd_rt;
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      if (exp_stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
      for (int i = 2; i > 0; i--) begin
        h_valid[i] = h_valid[i-1];
        h_wreg[i]  = h_wreg[i-1];
        h_tnew[i]  = h_tnew[i-1];
      end
      h_valid[0] = issue_valid && !exp_stall && issue_wen && issue_wreg != 5'd0;
      h_wreg[0]  = issue_wreg;
      h_tnew[0]  = int'(issue_tnew);
    end
    #1;
    $display("cycle t=%0t rst=%0b iv=%0b stall=%0b fwd_rs=%0d fwd_rt=%0d grf_wen=%0b grf_wreg=%0d cnt=%0d",
             $time, reset, issue_valid, last_stall, last_fwd_rs, last_fwd_rt, grf_wen, grf_wreg, stall_cnt);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
    end
  endtask

  initial begin
    model_clear();
    reset = 1'b1;
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    cyc();
    check("rst_stall", 32'(last_stall), 32'd0);
    check("rst_cnt", stall_cnt, 32'd0);
    reset = 1'b0;

    // load $5 (tnew 2) then add rs=$5 tuse 1: one stall cycle
    set_d(1, 1, 5, 2, 0, 0, 0, 0, 0, 0); cyc();
    set_d(1, 1, 6, 1, 1, 5, 1, 0, 0, 0); cyc();
    check("ld_use_stall1", 32'(last_stall), 32'd1);
    cyc();
    check("ld_use_stall2", 32'(last_stall), 32'd0);
    check("ld_use_cnt", stall_cnt, 32'd1);
    nops(3);

    // load $5 then beq rs=$5 tuse 0: two stalls, then issue from GRF
    set_d(1, 1, 5, 2, 0, 0, 0, 0, 0, 0); cyc();
    set_d(1, 0, 0, 0, 1, 5, 0, 1, 1, 0); cyc();
    check("beq_stall1", 32'(last_stall), 32'd1);
    cyc();
    check("beq_stall2", 32'(last_stall), 32'd1);
    cyc();
    check("beq_go", 32'(last_stall), 32'd0);
    check("beq_fwd", 32'(last_fwd_rs), 32'd0);
    nops(3);

    // lui $3 then addu rs=rt=$3: forward from E; with a gap, from M
    set_d(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); cyc();
    set_d(1, 1, 8, 1, 1, 3, 0, 1, 3, 0); cyc();
    check("lui_e_rt", 32'(last_fwd_rt), 32'd2);
    check("lui_e_rs", 32'(last_fwd_rs), 32'd2);
    nops(3);
    set_d(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); cyc();
    nops(1);
    set_d(1, 1, 8, 1, 0, 0, 0, 1, 3, 0); cyc();
    check("lui_m_rt", 32'(last_fwd_rt), 32'd1);
    nops(3);

    // ori $0 then beq rs=$0: never tracked
    set_d(1, 1, 0, 1, 0, 0, 0, 0, 0, 0); cyc();
    set_d(1, 0, 0, 0, 1, 0, 0, 0, 0, 0); cyc();
    check("r0_stall", 32'(last_stall), 32'd0);
    check("r0_fwd", 32'(last_fwd_rs), 32'd0);
    check("r0_wen", 32'(grf_wen), 32'd0);
    nops(3);

    // addu $7, lui $7, beq $7: youngest (E) wins
    set_d(1, 1, 7, 1, 0, 0, 0, 0, 0, 0); cyc();
    set_d(1, 1, 7, 0, 0, 0, 0, 0, 0, 0); cyc();
    set_d(1, 0, 0, 0, 1, 7, 0, 0, 0, 0); cyc();
    check("young_fwd", 32'(last_fwd_rs), 32'd2);
    check("young_stall", 32'(last_stall), 32'd0);
    check("young_w1", 32'({grf_wen, grf_wreg}), 32'({1'b1, 5'd7}));
    nops(1);
    check("young_w2", 32'({grf_wen, grf_wreg}), 32'({1'b1, 5'd7}));
    nops(3);

    // reset while stalled, then the D instruction issues freely
    set_d(1, 1, 5, 2, 0, 0, 0, 0, 0, 0); cyc();
    set_d(1, 1, 6, 1, 1, 5, 1, 0, 0, 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst_mid_stall", 32'(last_stall), 32'd1);
    check("rst_mid_cnt", stall_cnt, 32'd0);
    check("rst_mid_e", 32'(e_wreg), 32'd0);
    cyc();
    check("rst_mid_go", 32'(last_stall), 32'd0);
    nops(3);

    // random traffic on a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      set_d($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)),
            1'($urandom), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            1'($urandom), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grf_hazard_scoreboard.md
Name: grf_hazard_scoreboard

Overview:
- Tracks in-flight GRF writers in the E, M and W stages of the 5-stage pipeline.
- Generates the D-stage stall and the D-stage operand forward selects from Tuse/Tnew comparison.
- Drives the GRF write port (write enable and write register) from the W-stage entry.
- Sits beside the decoder. The datapath supplies the write data and write PC.

Parameters:
- TNEW_W, 2, width of Tnew/Tuse fields (max value 3)
- CNT_W, 32, width of the stall-cycle performance counter

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- issue_valid  input  1  D-stage instruction is valid and leaves D this cycle unless stalled
- issue_wen  input  1  D instruction writes the GRF
- issue_wreg  input  5  D instruction destination register
- issue_tnew  input  TNEW_W  cycles after entering E until the result is forwardable (ALU=1, load=2, lui/jal=0)
- rs_used  input  1  D instruction reads rs
- rs  input  5  rs index
- rs_tuse  input  TNEW_W  cycles after D until rs is consumed
- rt_used  input  1  D instruction reads rt
- rt  input  5  rt index
- rt_tuse  input  TNEW_W  cycles after D until rt is consumed
- stall  output  1  freeze PC/F/D and insert a bubble into E
- fwd_rs  output  2  D-stage rs source: 0=GRF (W covered by GRF internal bypass), 1=M, 2=E
- fwd_rt  output  2  same encoding for rt
- grf_wen  output  1  GRF write enable from the W entry
- grf_wreg  output  5  GRF write register from the W entry
- e_wreg, m_wreg  output  5 each  E/M destination registers (0 if entry invalid or no write), for later-stage forwarding muxes
- stall_cnt  output  CNT_W  number of stalled cycles since reset, saturating

Behaviour:
- State: three entries E, M, W. Each entry holds {valid, wreg[4:0], tnew}.
- An entry with wen=0 or wreg=0 is stored as valid=0, wreg=0.
- Advance every cycle, all updates at posedge clk:
  - W <= M, with tnew decremented and saturating at 0.
  - M <= E, with tnew decremented and saturating at 0.
  - E <= new D entry if issue_valid && !stall, else a bubble (valid=0).
- The pipeline never holds E/M/W; stalls only freeze F/D.
- Match: stage X matches source r when r != 0, X.valid=1 and X.wreg == r.
  - Priority is youngest first: E, then M, then W.
  - Only the youngest matching stage is considered.
- Stall (combinational from current state and D inputs). For each source with used=1:
  - Source stalls if the youngest matching stage has tnew > tuse.
  - stall = rs_stall | rt_stall.
  - stall is gated by issue_valid: no valid D instruction means stall=0.
- Forward select (combinational). For each source, among matching stages with tnew==0:
  - Youngest E match selects 2, else M match selects 1, else 0.
  - The W stage always selects 0 and relies on the GRF internal bypass.
  - If the youngest match has tnew>0, the select is don't-care but driven 0.
- grf_wen = W.valid; grf_wreg = W.wreg. Both are registered outputs and carry no combinational path from the inputs.
- stall_cnt increments on every cycle with stall=1 and saturates at all-ones.
- Reset:
  - All entries are cleared to invalid, wreg=0, tnew=0.
  - stall_cnt=0.
  - Consequently stall=0, fwd_*=0, grf_wen=0, grf_wreg=0, e_wreg=m_wreg=0.
  - Reset asserted mid-stall drops all in-flight entries on the next edge. The stall deasserts the following cycle.
- Boundary conditions:
  - Same register in E and M: E wins for both stall and forwarding.
  - rs == rt: both outputs are evaluated independently and give identical results.
  - rs_used=0 ignores rs entirely, even if it matches.
  - A destination of $0 is never tracked, never stalls and never forwards.
  - A stalled instruction re-evaluates each cycle as older entries advance and tnew decays. It issues in the first cycle where stall=0.

Test Plan:
- Load followed by use: load issued with $5/tnew=2, then add with rs=$5, tuse=1.
  - stall=1 for exactly 1 cycle (E tnew 2>1).
  - Next cycle M tnew=1 ≤ 1, so stall=0; stall_cnt=1.
- Load followed by beq (tuse=0) on $5: stall for 2 cycles. The instruction then issues with fwd_rs=0 (load in W, GRF bypass).
- ALU result used: lui $3 (tnew=0), then addu with rt=$3, tuse=0 → stall=0, fwd_rt=2. One cycle later, with a nop in between → fwd_rt=1.
- $0 destination: ori $0 (tnew=1), then beq rs=$0 → stall=0, fwd_rs=0, grf_wen=0 when it reaches W.
- Youngest-wins: addu $7 issued, then lui $7, then beq $7 → fwd_rs=2, not 1, stall=0. In W, grf_wreg=7 with grf_wen=1 for two consecutive cycles.
- Reset during the stall of the first scenario: on the next cycle all outputs are 0 and stall_cnt=0. The D instruction then issues with no stall.
